// File: rtl/simon_ti_pkg.sv
// Shared constants and FSM encoding for the bit-serial threshold-implemented Simon state.
package simon_ti_pkg;

    localparam int N_DEFAULT      = 64;
    localparam int ROUNDS_DEFAULT = 68;

    // Counter widths never collapse to zero, even for single-round builds.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    localparam int BIT_W = clog2_min1(N_DEFAULT);
    localparam int RND_W = clog2_min1(ROUNDS_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/simon_ti_share_reg.sv
// One share of the Simon state: x rotates under the taps while y collects the new x bits,
// and the two words swap roles at the end of every round.
module simon_ti_share_reg
    import simon_ti_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic           last,
    input  logic [2*N-1:0] pt,
    input  logic           lut_in,
    output logic           shift_out,
    output logic           rol1,
    output logic           rol2,
    output logic           rol8,
    output logic [2*N-1:0] ct
);

    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] x_rot;

    assign x_rot = {x[0], x[N-1:1]};

    // After N right-rotations x_rot is the original x again, which becomes the new y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= pt[2*N-1:N];
            y <= pt[N-1:0];
        end else if (step) begin
            if (last) begin
                x <= {lut_in, y[N-1:1]};
                y <= x_rot;
            end else begin
                x <= x_rot;
                y <= {lut_in, y[N-1:1]};
            end
        end
    end

    assign shift_out = y[0];
    assign rol1      = x[N-1];
    assign rol2      = x[N-2];
    assign rol8      = x[N-8];
    assign ct        = {x, y};

endmodule

// File: rtl/simon_ti_state_serial.sv
// Bit-serial 3-share Simon state register with round/bit sequencing; the round function
// and key schedule live outside and exchange one bit per share per cycle.
module simon_ti_state_serial
    import simon_ti_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2*N-1:0]          pt_a,
    input  logic [2*N-1:0]          pt_b,
    input  logic [2*N-1:0]          pt_c,
    output logic                    shift_out_a,
    output logic                    shift_out_b,
    output logic                    shift_out_c,
    output logic                    rol1_a,
    output logic                    rol1_b,
    output logic                    rol1_c,
    output logic                    rol2_a,
    output logic                    rol2_b,
    output logic                    rol2_c,
    output logic                    rol8_a,
    output logic                    rol8_b,
    output logic                    rol8_c,
    input  logic                    lut_in_a,
    input  logic                    lut_in_b,
    input  logic                    lut_in_c,
    output logic                    key_req,
    output logic [clog2_min1(N)-1:0] bit_idx,
    output logic                    busy,
    output logic                    done,
    output logic [2*N-1:0]          ct_a,
    output logic [2*N-1:0]          ct_b,
    output logic [2*N-1:0]          ct_c
);

    localparam int BW = clog2_min1(N);
    localparam int RW = clog2_min1(ROUNDS);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] round;
    logic          load;
    logic          step;
    logic          last_bit;

    assign last_bit = (bit_idx == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Rounds follow each other with no bubble; start is only honoured from IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (last_bit && (round == LAST_RND)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            round   <= '0;
        end else if (load) begin
            bit_idx <= '0;
            round   <= '0;
        end else if (step) begin
            if (last_bit) begin
                bit_idx <= '0;
                round   <= (round == LAST_RND) ? '0 : round + RW'(1);
            end else begin
                bit_idx <= bit_idx + BW'(1);
            end
        end
    end

    assign key_req = (state == ROUND);
    assign busy    = (state == ROUND);
    assign done    = (state == DONE);

    simon_ti_share_reg #(.N(N)) u_share_a (
        .clk(clk), .rst_n(rst_n), .load(load), .step(step), .last(last_bit),
        .pt(pt_a), .lut_in(lut_in_a), .shift_out(shift_out_a),
        .rol1(rol1_a), .rol2(rol2_a), .rol8(rol8_a), .ct(ct_a)
    );

    simon_ti_share_reg #(.N(N)) u_share_b (
        .clk(clk), .rst_n(rst_n), .load(load), .step(step), .last(last_bit),
        .pt(pt_b), .lut_in(lut_in_b), .shift_out(shift_out_b),
        .rol1(rol1_b), .rol2(rol2_b), .rol8(rol8_b), .ct(ct_b)
    );

    simon_ti_share_reg #(.N(N)) u_share_c (
        .clk(clk), .rst_n(rst_n), .load(load), .step(step), .last(last_bit),
        .pt(pt_c), .lut_in(lut_in_c), .shift_out(shift_out_c),
        .rol1(rol1_c), .rol2(rol2_c), .rol8(rol8_c), .ct(ct_c)
    );

endmodule

// File: tb/tb_simon_ti_state_serial.sv
// Scoreboard bench: an external TI round function and Simon128/128 key schedule drive the DUT,
// and a monitor checks taps, latency and unmasked ciphertext against bench-computed values.
module tb_simon_ti_state_serial;

    localparam int N       = 64;
    localparam int ROUNDS  = 68;
    localparam int LATENCY = N * ROUNDS + 1;

    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_PT  = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

    typedef struct {
        logic [127:0] ct;
        int           start_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] pt_a, pt_b, pt_c;
    logic         shift_out_a, shift_out_b, shift_out_c;
    logic         rol1_a, rol1_b, rol1_c;
    logic         rol2_a, rol2_b, rol2_c;
    logic         rol8_a, rol8_b, rol8_c;
    logic         lut_in_a, lut_in_b, lut_in_c;
    logic         key_req;
    logic [5:0]   bit_idx;
    logic         busy;
    logic         done;
    logic [127:0] ct_a, ct_b, ct_c;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           key_cnt = 0;
    logic [63:0]  rk [ROUNDS];
    logic [63:0]  px [3];
    logic [63:0]  py [3];
    exp_t         sb [$];
    logic [127:0] last_ct_a = '0;

    simon_ti_state_serial #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pt_a(pt_a), .pt_b(pt_b), .pt_c(pt_c),
        .shift_out_a(shift_out_a), .shift_out_b(shift_out_b), .shift_out_c(shift_out_c),
        .rol1_a(rol1_a), .rol1_b(rol1_b), .rol1_c(rol1_c),
        .rol2_a(rol2_a), .rol2_b(rol2_b), .rol2_c(rol2_c),
        .rol8_a(rol8_a), .rol8_b(rol8_b), .rol8_c(rol8_c),
        .lut_in_a(lut_in_a), .lut_in_b(lut_in_b), .lut_in_c(lut_in_c),
        .key_req(key_req), .bit_idx(bit_idx), .busy(busy), .done(done),
        .ct_a(ct_a), .ct_b(ct_b), .ct_c(ct_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Simon128/128 key expansion using the z2 constant sequence (z2[0] is the leftmost bit).
    task automatic expandKey(input logic [127:0] key);
        logic [61:0] z2;
        logic [63:0] c;
        z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
        c  = 64'hFFFF_FFFF_FFFF_FFFC;
        rk[0] = key[63:0];
        rk[1] = key[127:64];
        for (int i = 0; i < ROUNDS - 2; i++) begin
            rk[i+2] = c ^ {63'd0, z2[61 - (i % 62)]} ^ rk[i] ^ ror64(rk[i+1], 3) ^ ror64(rk[i+1], 4);
        end
    endtask

    function automatic logic [127:0] simonEncrypt(input logic [127:0] pt);
        logic [63:0] x, y, t;
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ ((rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2)) ^ rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: models the three lut_datapath instances, checks round-0 taps and scores each done.
    always @(negedge clk) begin
        logic         kb, nl_a, nl_b, nl_c;
        logic [127:0] act_taps, exp_taps;
        exp_t         e;
        int           k;
        if (!rst_n) begin
            key_cnt = 0;
        end else begin
            if (key_req) begin
                if (key_cnt < N) begin
                    k = key_cnt;
                    act_taps = {107'd0, bit_idx, rol1_a, rol1_b, rol1_c, rol2_a, rol2_b, rol2_c,
                                rol8_a, rol8_b, rol8_c, shift_out_a, shift_out_b, shift_out_c};
                    exp_taps = {107'd0, 6'(k),
                                px[0][(k+N-1)%N], px[1][(k+N-1)%N], px[2][(k+N-1)%N],
                                px[0][(k+N-2)%N], px[1][(k+N-2)%N], px[2][(k+N-2)%N],
                                px[0][(k+N-8)%N], px[1][(k+N-8)%N], px[2][(k+N-8)%N],
                                py[0][k], py[1][k], py[2][k]};
                    checkOutput("round0_taps", act_taps, exp_taps);
                end
                checks++;
                if (!busy) begin
                    errors++;
                    $display("[TB] FAIL busy_in_round: got %b expected 1 at key_cnt %0d", busy, key_cnt);
                end
                kb   = rk[key_cnt / N][key_cnt % N];
                nl_a = (rol1_b & rol8_b) ^ (rol1_b & rol8_c) ^ (rol1_c & rol8_b);
                nl_b = (rol1_c & rol8_c) ^ (rol1_c & rol8_a) ^ (rol1_a & rol8_c);
                nl_c = (rol1_a & rol8_a) ^ (rol1_a & rol8_b) ^ (rol1_b & rol8_a);
                lut_in_a = shift_out_a ^ rol2_a ^ nl_a ^ kb;
                lut_in_b = shift_out_b ^ rol2_b ^ nl_b;
                lut_in_c = shift_out_c ^ rol2_c ^ nl_c;
                key_cnt++;
            end else begin
                key_cnt  = 0;
                lut_in_a = 1'($urandom_range(0, 1));
                lut_in_b = 1'($urandom_range(0, 1));
                lut_in_c = 1'($urandom_range(0, 1));
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no pending run at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ct_unmasked", ct_a ^ ct_b ^ ct_c, e.ct);
                    checkOutput("latency", 128'(cyc - e.start_cyc), 128'(LATENCY));
                    checkOutput("busy_at_done", {127'd0, busy}, 128'd0);
                    checks++;
                    if (ct_a == last_ct_a) begin
                        errors++;
                        $display("[TB] FAIL ct_a_differs: got %h expected a value other than %h", ct_a, last_ct_a);
                    end
                    last_ct_a = ct_a;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] mb, input logic [127:0] mc,
                                 input logic [127:0] exp_ct, input bit b2b, input bit pulses);
        logic [127:0] prev_ct, prev_a;
        if (!b2b) @(negedge clk);
        pt_b  = mb;
        pt_c  = mc;
        pt_a  = pt ^ mb ^ mc;
        px[0] = pt_a[127:64]; py[0] = pt_a[63:0];
        px[1] = pt_b[127:64]; py[1] = pt_b[63:0];
        px[2] = pt_c[127:64]; py[2] = pt_c[63:0];
        start = 1'b1;
        if (b2b) begin
            prev_ct = ct_a ^ ct_b ^ ct_c;
            prev_a  = ct_a;
            @(negedge clk);
            checkOutput("b2b_ct_hold", ct_a ^ ct_b ^ ct_c, prev_ct);
            checkOutput("b2b_cta_hold", ct_a, prev_a);
            checkOutput("b2b_idle_flags", {126'd0, busy, done}, 128'd0);
        end
        sb.push_back('{exp_ct, cyc});
        @(negedge clk);
        start = 1'b0;
        if (pulses) begin
            repeat (9) @(negedge clk);
            pt_a  = ~pt_a;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2989) @(negedge clk);
            pt_b  = ~pt_b;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 6000 cycles", name);
        end
    endtask

    function automatic logic [127:0] rndMask();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] tap_pt;
        rst_n = 1'b0;
        start = 1'b0;
        pt_a  = '0;
        pt_b  = '0;
        pt_c  = '0;
        expandKey(KAT_KEY);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", {114'd0, busy, done, key_req, bit_idx, rol1_a, rol1_b, rol1_c,
                    rol2_a, rol2_b, rol2_c, rol8_a, rol8_b, rol8_c, shift_out_a, shift_out_b, shift_out_c},
                    128'd0);
        checkOutput("reset_ct_a", ct_a, 128'd0);
        checkOutput("reset_ct_b", ct_b, 128'd0);
        checkOutput("reset_ct_c", ct_c, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] KAT with mask set 1 and ignored mid-run starts");
        applyStimulus(KAT_PT, rndMask(), rndMask(), KAT_CT, 1'b0, 1'b1);
        waitDone("kat1");

        $display("[TB] KAT with mask set 2 started back-to-back");
        applyStimulus(KAT_PT, rndMask(), rndMask(), KAT_CT, 1'b1, 1'b0);
        waitDone("kat2");
        @(negedge clk);
        checkOutput("done_single_pulse", {126'd0, done, busy}, 128'd0);

        $display("[TB] KAT with mask set 3");
        applyStimulus(KAT_PT, rndMask(), rndMask(), KAT_CT, 1'b0, 1'b0);
        waitDone("kat3");

        $display("[TB] single-bit x tap pattern");
        tap_pt = {64'h0000_0000_0000_0001, 64'hF0E1_D2C3_B4A5_9687};
        applyStimulus(tap_pt, 128'd0, 128'd0, simonEncrypt(tap_pt), 1'b0, 1'b0);
        waitDone("taps");

        $display("[TB] reset abort mid-run");
        applyStimulus(KAT_PT, rndMask(), rndMask(), KAT_CT, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_flags", {114'd0, busy, done, key_req, bit_idx, rol1_a, rol1_b, rol1_c,
                    rol2_a, rol2_b, rol2_c, rol8_a, rol8_b, rol8_c, shift_out_a, shift_out_b, shift_out_c},
                    128'd0);
        checkOutput("abort_ct_a", ct_a, 128'd0);
        checkOutput("abort_ct_b", ct_b, 128'd0);
        checkOutput("abort_ct_c", ct_c, 128'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("abort_stays_idle", {125'd0, busy, done, key_req}, 128'd0);

        $display("[TB] KAT with mask set 4 after reset");
        applyStimulus(KAT_PT, rndMask(), rndMask(), KAT_CT, 1'b0, 1'b0);
        waitDone("kat4");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
